// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side constants and types: reset vector, fetch exception codes,
// FSM encoding and the decode hand-off slot payload.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [EXC_W-1:0]  EXC_ADEL_DEF = 5'h04;
  localparam logic [EXC_W-1:0]  EXC_TLBL_DEF = 5'h02;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              cancelled;
    logic              exc;
    logic              exc_miss;
    logic [EXC_W-1:0]  exccode;
  } fetch_slot_t;

  localparam fetch_slot_t SLOT_EMPTY = '0;

  // Fetch exception code: misalignment outranks any ITLB fault.
  function automatic logic [EXC_W-1:0] fault_code(input logic misaligned,
                                                   input logic [EXC_W-1:0] adel,
                                                   input logic [EXC_W-1:0] tlbl);
    return misaligned ? adel : tlbl;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one word read per
// instruction and hands a slot (pc / cancel / exception) to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [EXC_W-1:0]  EXC_ADEL = EXC_ADEL_DEF,
  parameter logic [EXC_W-1:0]  EXC_TLBL = EXC_TLBL_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              itlb_refill_i,
  input  logic              itlb_invalid_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              cancelled_o,
  output logic              exc_o,
  output logic              exc_miss_o,
  output logic [EXC_W-1:0]  exccode_o,
  output logic [31:0]       perfcnt_fetch_waitaddr
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  fetch_slot_t       r_slot;
  fetch_slot_t       w_slot_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       r_perf;

  logic w_can_load;
  logic w_misaligned;
  logic w_fault;
  logic w_load_req;
  logic w_load_exc;

  assign w_can_load   = !r_slot.valid || ready_i;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_fault      = w_misaligned || itlb_refill_i || itlb_invalid_i;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_REQ;
    else         r_state <= w_state_nxt;
  end

  // Next state: a redirect always restarts fetching; a fault slot parks in HALT
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_REQ: begin
        if (redirect_i)                   w_state_nxt = ST_REQ;
        else if (w_can_load && w_fault)   w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (redirect_i) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  // FSM outputs
  always_comb begin
    inst_req   = 1'b0;
    w_load_req = 1'b0;
    w_load_exc = 1'b0;
    if (r_state == ST_REQ) begin
      inst_req   = w_can_load && !w_fault;
      w_load_req = inst_req && inst_addr_ok;
      w_load_exc = w_can_load && w_fault;
    end
  end

  // Slot and PC update; a redirect marks whatever is loaded or held as squashed
  always_comb begin
    w_slot_nxt = r_slot;
    w_pc_nxt   = r_pc;
    if (w_load_req) begin
      w_slot_nxt           = SLOT_EMPTY;
      w_slot_nxt.valid     = 1'b1;
      w_slot_nxt.pc        = r_pc;
      w_slot_nxt.cancelled = redirect_i;
      w_pc_nxt             = r_pc + ADDR_W'(4);
    end else if (w_load_exc) begin
      w_slot_nxt.valid     = 1'b1;
      w_slot_nxt.pc        = r_pc;
      w_slot_nxt.cancelled = redirect_i;
      w_slot_nxt.exc       = 1'b1;
      w_slot_nxt.exc_miss  = itlb_refill_i && !w_misaligned;
      w_slot_nxt.exccode   = fault_code(w_misaligned, EXC_ADEL, EXC_TLBL);
    end else if (r_slot.valid && ready_i) begin
      w_slot_nxt = SLOT_EMPTY;
    end else if (r_slot.valid && redirect_i) begin
      w_slot_nxt.cancelled = 1'b1;
    end
    if (redirect_i) w_pc_nxt = redirect_pc_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot <= SLOT_EMPTY;
      r_pc   <= RESET_PC;
    end else begin
      r_slot <= w_slot_nxt;
      r_pc   <= w_pc_nxt;
    end
  end

  // Address-handshake stall counter, free-running and wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         r_perf <= '0;
    else if (inst_req && !inst_addr_ok)  r_perf <= r_perf + 32'(1);
  end

  assign inst_wr                = 1'b0;
  assign inst_size              = 2'd2;
  assign inst_addr              = r_pc;
  assign valid_o                = r_slot.valid;
  assign pc_o                   = r_slot.pc;
  assign cancelled_o            = r_slot.cancelled;
  assign exc_o                  = r_slot.exc;
  assign exc_miss_o             = r_slot.exc_miss;
  assign exccode_o              = r_slot.exccode;
  assign perfcnt_fetch_waitaddr = r_perf;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table with hand-computed
// pre-edge expectations, plus an asynchronous mid-request reset sequence.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        itlb_refill_i, itlb_invalid_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic        cancelled_o, exc_o, exc_miss_o;
  logic [4:0]  exccode_o;
  logic [31:0] perfcnt_fetch_waitaddr;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .inst_req               (inst_req),
    .inst_wr                (inst_wr),
    .inst_size              (inst_size),
    .inst_addr              (inst_addr),
    .inst_addr_ok           (inst_addr_ok),
    .itlb_refill_i          (itlb_refill_i),
    .itlb_invalid_i         (itlb_invalid_i),
    .redirect_i             (redirect_i),
    .redirect_pc_i          (redirect_pc_i),
    .ready_i                (ready_i),
    .valid_o                (valid_o),
    .pc_o                   (pc_o),
    .cancelled_o            (cancelled_o),
    .exc_o                  (exc_o),
    .exc_miss_o             (exc_miss_o),
    .exccode_o              (exccode_o),
    .perfcnt_fetch_waitaddr (perfcnt_fetch_waitaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aok, rdy, rf, inv, rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        canc, exc, miss;
    logic [4:0]  code;
    logic [31:0] perf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic aok, rdy, rf, inv, rd, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic canc, exc, miss,
                              input logic [4:0] code, input logic [31:0] perf);
    vec_t v;
    v.aok = aok; v.rdy = rdy; v.rf = rf; v.inv = inv; v.rd = rd; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    v.canc = canc; v.exc = exc; v.miss = miss; v.code = code; v.perf = perf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [step %0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic aok, rdy, rf, inv, rd, input logic [31:0] rpc);
    inst_addr_ok   = aok;
    ready_i        = rdy;
    itlb_refill_i  = rf;
    itlb_invalid_i = inv;
    redirect_i     = rd;
    redirect_pc_i  = rpc;
  endtask

  initial begin
    // Each row: inputs for the cycle, then outputs expected just before its rising edge
    //             aok rdy rf inv rd  rpc           req addr          vld pc            cnc exc mis code   perf
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        0, 0, 0, 5'h00, 0)); // 0
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'hbfc00004, 1, 32'hbfc00000, 0, 0, 0, 5'h00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'hbfc00008, 1, 32'hbfc00004, 0, 0, 0, 5'h00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 32'hbfc0000c, 1, 32'hbfc00008, 0, 0, 0, 5'h00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0,        0, 0, 0, 5'h00, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0,        0, 0, 0, 5'h00, 2)); // 5
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0,        0, 0, 0, 5'h00, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 32'hbfc00010, 1, 32'hbfc0000c, 0, 0, 0, 5'h00, 3));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'hbfc00010, 1, 32'hbfc0000c, 0, 0, 0, 5'h00, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h80001000, 0, 32'hbfc00014, 1, 32'hbfc00010, 0, 0, 0, 5'h00, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h80001000, 1, 32'hbfc00010, 1, 0, 0, 5'h00, 3)); // 10
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'h80001000, 1, 32'hbfc00010, 1, 0, 0, 5'h00, 3));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h80000002, 1, 32'h80001004, 1, 32'h80001000, 0, 0, 0, 5'h00, 3));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h80000002, 0, 32'h0,        0, 0, 0, 5'h00, 4));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h80000002, 1, 32'h80000002, 0, 1, 0, 5'h04, 4));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h80000002, 0, 32'h0,        0, 0, 0, 5'h00, 4)); // 15
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h80000000, 0, 32'h80000002, 0, 32'h0,        0, 0, 0, 5'h00, 4));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'h80000000, 0, 32'h0,        0, 0, 0, 5'h00, 4));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,        0, 32'h80000004, 1, 32'h80000000, 0, 0, 0, 5'h00, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h80000004, 1, 32'h80000004, 0, 1, 1, 5'h02, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h80002000, 0, 32'h80000004, 1, 32'h80000004, 0, 1, 1, 5'h02, 4)); // 20
    vecs.push_back(mk(1, 1, 0, 1, 1, 32'h80003000, 0, 32'h80002000, 0, 32'h0,        0, 0, 0, 5'h00, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h80003000, 1, 32'h80002000, 1, 1, 0, 5'h02, 4));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h80004000, 1, 32'h80003000, 1, 32'h80002000, 1, 1, 0, 5'h02, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 32'h80004000, 1, 32'h80003000, 1, 0, 0, 5'h00, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'hfffffffc, 1, 32'h80004000, 0, 32'h0,        0, 0, 0, 5'h00, 5)); // 25
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        1, 32'hfffffffc, 0, 32'h0,        0, 0, 0, 5'h00, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 32'h00000000, 1, 32'hfffffffc, 0, 0, 0, 5'h00, 6));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h00000001, 1, 32'h00000000, 0, 32'h0,        0, 0, 0, 5'h00, 7));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,        0, 32'h00000001, 0, 32'h0,        0, 0, 0, 5'h00, 8));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h00000001, 1, 32'h00000001, 0, 1, 0, 5'h04, 8)); // 30

    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr",  -1, inst_addr, 32'hbfc00000);
    check("rst_valid", -1, 32'(valid_o), 32'h0);
    check("rst_perf",  -1, perfcnt_fetch_waitaddr, 32'h0);
    check("rst_wr",    -1, 32'(inst_wr), 32'h0);
    check("rst_size",  -1, 32'(inst_size), 32'h2);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].aok, vecs[i].rdy, vecs[i].rf, vecs[i].inv, vecs[i].rd, vecs[i].rpc);
      #1;
      check("inst_req",    i, 32'(inst_req),    32'(vecs[i].req));
      check("inst_addr",   i, inst_addr,        vecs[i].addr);
      check("valid_o",     i, 32'(valid_o),     32'(vecs[i].vld));
      check("pc_o",        i, pc_o,             vecs[i].pc);
      check("cancelled_o", i, 32'(cancelled_o), 32'(vecs[i].canc));
      check("exc_o",       i, 32'(exc_o),       32'(vecs[i].exc));
      check("exc_miss_o",  i, 32'(exc_miss_o),  32'(vecs[i].miss));
      check("exccode_o",   i, 32'(exccode_o),   32'(vecs[i].code));
      check("perfcnt",     i, perfcnt_fetch_waitaddr, vecs[i].perf);
      @(negedge clk);
    end

    // Mid-request asynchronous reset: leave HALT, stall a request, reset before the edge
    drive(0, 1, 0, 0, 1, 32'h80005000);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 32'h0);
    #1;
    check("mr_req_pre",  100, 32'(inst_req), 32'h1);
    check("mr_addr_pre", 100, inst_addr, 32'h80005000);
    #1;
    resetn = 1'b0;
    #1;
    check("mr_addr",  101, inst_addr, 32'hbfc00000);
    check("mr_valid", 101, 32'(valid_o), 32'h0);
    check("mr_perf",  101, perfcnt_fetch_waitaddr, 32'h0);
    check("mr_req",   101, 32'(inst_req), 32'h1);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 1, 0, 0, 0, 32'h0);
    #1;
    check("mr_req_post", 102, 32'(inst_req), 32'h1);
    @(negedge clk);
    #1;
    check("mr_slot_valid", 103, 32'(valid_o), 32'h1);
    check("mr_slot_pc",    103, pc_o, 32'hbfc00000);
    check("mr_next_addr",  103, inst_addr, 32'hbfc00004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
